// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-client ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultOpw   = 4;

  // Sequencer states: accept, ALU sampling cycle, result capture
  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StCapt
  } state_e;

  // ALU opcodes
  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSlti = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpOr   = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpAndi = 4'd6;
  localparam logic [3:0] OpOri  = 4'd7;
  localparam logic [3:0] OpXori = 4'd8;
  localparam logic [3:0] OpAddi = 4'd9;
  localparam logic [3:0] OpSubi = 4'd10;

  // Bit positions inside the 3-bit {overflow, zero, neg} flag vector
  localparam int unsigned FlagNeg  = 0;
  localparam int unsigned FlagZero = 1;
  localparam int unsigned FlagOvf  = 2;

endpackage

// File: rtl/alu_arb_rr.sv
// Combinational two-way round-robin pick. ptr names the preferred client;
// the other client wins only when the preferred one is not requesting.
module alu_arb_rr (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant from the valids and the preference pointer
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~ptr | ~valid[1]);
    grant[1] = valid[1] & (ptr | ~valid[0]);
  end

endmodule

// File: rtl/alu_arb.sv
// Two-client arbiter/sequencer in front of the shared registered ALU.
// Grants round-robin, issues the operation, waits out the ALU latency and
// returns result and flags as a one-cycle pulse to the granted client.
// Optional: define ALU_ARB_STATS_EN for saturating per-client grant counters.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned OPW   = DefaultOpw
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
`endif
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_codop,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_codop,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_out,
  output logic [2:0]       rsp0_flags,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_out,
  output logic [2:0]       rsp1_flags,
  output logic [OPW-1:0]   alu_codop,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_overflow
);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       gid_q;      // client owning the in-flight operation
  logic [1:0] pick;
  logic [1:0] hs;         // one-hot handshake this cycle
  logic [2:0] alu_flags;
  logic       capt;

  alu_arb_rr u_rr (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr_q),
    .grant (pick)
  );

  // Next state, handshake decode and pointer rotation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hs      = 2'b00;
    unique case (state_q)
      StIdle: begin
        // Reset suppresses acceptance so no handshake is lost on the reset edge
        hs = rst ? 2'b00 : pick;
        if (hs != 2'b00) begin
          state_d = StExec;
          ptr_d   = hs[0];
        end
      end
      StExec:  state_d = StCapt;
      StCapt:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready outputs and flag packing
  always_comb begin
    req0_ready          = hs[0];
    req1_ready          = hs[1];
    capt                = (state_q == StCapt);
    alu_flags           = 3'b000;
    alu_flags[FlagNeg]  = alu_neg;
    alu_flags[FlagZero] = alu_zero;
    alu_flags[FlagOvf]  = alu_overflow;
  end

  // FSM state and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Issue registers: load the granted operation, hold it between grants
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_codop <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      gid_q     <= 1'b0;
    end else if (hs != 2'b00) begin
      alu_codop <= hs[1] ? req1_codop : req0_codop;
      alu_a     <= hs[1] ? req1_a : req0_a;
      alu_b     <= hs[1] ? req1_b : req0_b;
      gid_q     <= hs[1];
    end
  end

  // Response registers: data holds after the pulse, only valid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_out   <= '0;
      rsp1_out   <= '0;
      rsp0_flags <= '0;
      rsp1_flags <= '0;
    end else begin
      rsp0_valid <= capt & ~gid_q;
      rsp1_valid <= capt & gid_q;
      if (capt && !gid_q) begin
        rsp0_out   <= alu_out;
        rsp0_flags <= alu_flags;
      end
      if (capt && gid_q) begin
        rsp1_out   <= alu_out;
        rsp1_flags <= alu_flags;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Saturating grant counters per client
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (hs[0] && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (hs[1] && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: a registered ALU model drives alu_out,
// a transaction-level model predicts readys/responses every cycle, and
// directed phases pin literal results.
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_codop, req1_codop, alu_codop;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out;
  logic        rsp0_valid, rsp1_valid, alu_neg, alu_zero, alu_overflow;
  logic [15:0] rsp0_out, rsp1_out;
  logic [2:0]  rsp0_flags, rsp1_flags;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arb dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
`endif
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_codop   (req0_codop),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_codop   (req1_codop),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp0_valid   (rsp0_valid),
    .rsp0_out     (rsp0_out),
    .rsp0_flags   (rsp0_flags),
    .rsp1_valid   (rsp1_valid),
    .rsp1_out     (rsp1_out),
    .rsp1_flags   (rsp1_flags),
    .alu_codop    (alu_codop),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .alu_neg      (alu_neg),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  // ALU behaviour: returns {overflow, zero, neg, result}
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic        ov;
    ov = 1'b0;
    case (op)
      OpAdd, OpAddi: begin
        r  = a + b;
        ov = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OpSub, OpSubi: begin
        r  = a - b;
        ov = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OpSlti:        r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      OpAnd, OpAndi: r = a & b;
      OpOr, OpOri:   r = a | b;
      OpXor, OpXori: r = a ^ b;
      default:       r = 16'd0;
    endcase
    return {ov, (r == 16'd0), r[15], r};
  endfunction

  // Shared ALU with one cycle of registered latency
  always @(posedge clk)
    {alu_overflow, alu_zero, alu_neg, alu_out} <= alu_fn(alu_codop, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int unsigned due;
    bit          client;
    logic [18:0] res;
  } pend_t;

  pend_t       pend[$];
  bit          armed = 1'b0;
  int          busy;
  bit          pref;
  logic [15:0] m_out0, m_out1, m_a, m_b;
  logic [2:0]  m_fl0, m_fl1;
  logic [3:0]  m_codop;

  task automatic model_reset();
    pend.delete();
    busy    = 0;
    pref    = 1'b0;
    m_out0  = '0;
    m_out1  = '0;
    m_fl0   = '0;
    m_fl1   = '0;
    m_codop = '0;
    m_a     = '0;
    m_b     = '0;
  endtask

  task automatic issue(input bit client, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    pend_t p;
    p.due    = cyc + 3;
    p.client = client;
    p.res    = alu_fn(op, a, b);
    pend.push_back(p);
    busy    = 2;
    pref    = ~client;
    m_codop = op;
    m_a     = a;
    m_b     = b;
  endtask

  always @(negedge clk) begin : model_cmp
    logic e_rv0, e_rv1, e_rd0, e_rd1;
    if (!armed) begin
      if (rst) begin
        armed = 1'b1;
        model_reset();
      end
    end else begin
      e_rv0 = 1'b0;
      e_rv1 = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].due == cyc) begin
          if (pend[i].client) begin
            e_rv1  = 1'b1;
            m_out1 = pend[i].res[15:0];
            m_fl1  = pend[i].res[18:16];
          end else begin
            e_rv0  = 1'b1;
            m_out0 = pend[i].res[15:0];
            m_fl0  = pend[i].res[18:16];
          end
          pend.delete(i);
        end
      end
      e_rd0 = !rst && busy == 0 && req0_valid && (!pref || !req1_valid);
      e_rd1 = !rst && busy == 0 && req1_valid && (pref || !req0_valid);
      chk("m_ready0", req0_ready, e_rd0);
      chk("m_ready1", req1_ready, e_rd1);
      chk("m_rsp0_valid", rsp0_valid, e_rv0);
      chk("m_rsp1_valid", rsp1_valid, e_rv1);
      chk("m_rsp0_out", rsp0_out, m_out0);
      chk("m_rsp1_out", rsp1_out, m_out1);
      chk("m_rsp0_flags", rsp0_flags, m_fl0);
      chk("m_rsp1_flags", rsp1_flags, m_fl1);
      chk("m_alu_codop", alu_codop, m_codop);
      chk("m_alu_a", alu_a, m_a);
      chk("m_alu_b", alu_b, m_b);
      if (rst) model_reset();
      else begin
        if (busy > 0) busy--;
        if (e_rd0) issue(1'b0, req0_codop, req0_a, req0_b);
        else if (e_rd1) issue(1'b1, req1_codop, req1_a, req1_b);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_wait(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (n) nxt();
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_codop = OpXor;
    req0_a     = 16'd170;
    req0_b     = 16'd255;
    req1_codop = OpAnd;
    req1_a     = 16'd170;
    req1_b     = 16'd255;

    // Reset held two cycles with both clients requesting
    nxt();
    sample();
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_alu_codop", alu_codop, 4'd0);
    chk("rst_alu_a", alu_a, 16'd0);
    chk("rst_alu_b", alu_b, 16'd0);
    nxt();
    rst = 1'b0;

    // Contention: T = first cycle out of reset
    sample();
    chk("ct_T_ready0", req0_ready, 1'b1);
    chk("ct_T_ready1", req1_ready, 1'b0);
    nxt();
    sample();
    chk("ct_T1_ready0", req0_ready, 1'b0);
    chk("ct_T1_codop", alu_codop, OpXor);
    chk("ct_T1_a", alu_a, 16'd170);
    chk("ct_T1_b", alu_b, 16'd255);
    nxt();
    nxt();
    sample();
    chk("ct_T3_rsp0_valid", rsp0_valid, 1'b1);
    chk("ct_T3_rsp0_out", rsp0_out, 16'd85);
    chk("ct_T3_rsp0_flags", rsp0_flags, 3'b000);
    chk("ct_T3_ready1", req1_ready, 1'b1);
    chk("ct_T3_ready0", req0_ready, 1'b0);
    nxt();
    nxt();
    nxt();
    sample();
    chk("ct_T6_rsp1_valid", rsp1_valid, 1'b1);
    chk("ct_T6_rsp1_out", rsp1_out, 16'd170);
    chk("ct_T6_rsp0_valid", rsp0_valid, 1'b0);
    chk("ct_T6_ready0", req0_ready, 1'b1);
    nxt();
    idle_wait(4);

    // Single op: ADD 170 + 255 from client 0
    req0_valid = 1'b1;
    req0_codop = OpAdd;
    req0_a     = 16'd170;
    req0_b     = 16'd255;
    sample();
    chk("add_ready0", req0_ready, 1'b1);
    nxt();
    req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sample();
      chk("add_rsp0_valid", rsp0_valid, (k == 3));
      chk("add_rsp1_valid", rsp1_valid, 1'b0);
      if (k == 3) begin
        chk("add_rsp0_out", rsp0_out, 16'd425);
        chk("add_rsp0_flags", rsp0_flags, 3'b000);
      end
      nxt();
    end
    idle_wait(2);

    // Streaming: client 1 SUB 255 - 170 held valid
    req1_valid = 1'b1;
    req1_codop = OpSub;
    req1_a     = 16'd255;
    req1_b     = 16'd170;
    for (int k = 0; k <= 9; k++) begin
      sample();
      chk("st_ready1", req1_ready, (k % 3 == 0));
      chk("st_rsp1_valid", rsp1_valid, (k >= 3 && k % 3 == 0));
      chk("st_rsp0_valid", rsp0_valid, 1'b0);
      if (k >= 3 && k % 3 == 0) chk("st_rsp1_out", rsp1_out, 16'd85);
      nxt();
    end
    idle_wait(4);

    // Reset during EXEC drops the operation and re-prefers client 0
    req0_valid = 1'b1;
    req0_codop = OpAdd;
    req0_a     = 16'd1;
    req0_b     = 16'd2;
    req1_valid = 1'b1;
    req1_codop = OpAnd;
    sample();
    chk("mr_T_ready0", req0_ready, 1'b1);
    nxt();
    rst = 1'b1;
    sample();
    chk("mr_T1_ready0", req0_ready, 1'b0);
    chk("mr_T1_ready1", req1_ready, 1'b0);
    nxt();
    rst = 1'b0;
    sample();
    chk("mr_T2_ready0", req0_ready, 1'b1);
    chk("mr_T2_ready1", req1_ready, 1'b0);
    chk("mr_T2_rsp0_out", rsp0_out, 16'd0);
    chk("mr_T2_rsp1_out", rsp1_out, 16'd0);
    chk("mr_T2_alu_a", alu_a, 16'd0);
    nxt();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sample();
    chk("mr_T3_rsp0_valid", rsp0_valid, 1'b0);
    nxt();
    idle_wait(5);

`ifdef ALU_ARB_STATS_EN
    begin : stats
      int g0, g1;
      g0  = 0;
      g1  = 0;
      rst = 1'b1;
      nxt();
      nxt();
      rst        = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int k = 0; k < 60; k++) begin
        sample();
        if (req0_ready) g0++;
        if (req1_ready) g1++;
        nxt();
        if (g0 + g1 == 6) req1_valid = 1'b0;
        if (g0 + g1 == 8) begin
          req0_valid = 1'b0;
          break;
        end
      end
      idle_wait(4);
      sample();
      chk("stat_cnt0", grant_cnt0, 16'd5);
      chk("stat_cnt1", grant_cnt1, 16'd3);
      nxt();
      force dut.cnt0_q = 16'hFFFF;
      nxt();
      release dut.cnt0_q;
      req0_valid = 1'b1;
      sample();
      chk("stat_sat_ready0", req0_ready, 1'b1);
      nxt();
      req0_valid = 1'b0;
      nxt();
      sample();
      chk("stat_sat_cnt0", grant_cnt0, 16'hFFFF);
      chk("stat_sat_cnt1", grant_cnt1, 16'd3);
      idle_wait(4);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
